// File: rtl/mode_counter.sv
// Mode-selectable registered counter: up, down, up-by-STEP or parallel load.
// The registered ripple-carry output cascades into the next stage's iCarryIn.
module mode_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iEnb,
  input  logic             iCarryIn,
  input  logic [1:0]       iMode,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ,
  output logic             oRco
);

  localparam logic [WIDTH:0]   StepExt = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-1:0] Zero    = '0;

  logic [WIDTH-1:0] q_d, q_q;
  logic             rco_d, rco_q;
  logic [WIDTH:0]   step_sum;

  // The extra sum bit is the wrap flag for the up-by-STEP mode.
  assign step_sum = {1'b0, q_q} + StepExt;

  always_comb begin
    q_d   = q_q;
    rco_d = 1'b0;
    if (!iEnb) begin
      case (iMode)
        2'b00: begin
          if (iCarryIn) begin
            q_d   = q_q + One;
            rco_d = (q_q == AllOnes);
          end
        end
        2'b01: begin
          if (iCarryIn) begin
            q_d   = q_q - One;
            rco_d = (q_q == Zero);
          end
        end
        2'b10: begin
          if (iCarryIn) begin
            q_d   = step_sum[WIDTH-1:0];
            rco_d = step_sum[WIDTH];
          end
        end
        2'b11: begin
          q_d = iD;
        end
        // Unknown select while operating: hold and suppress the carry.
        default: begin
          q_d   = q_q;
          rco_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iClr) begin
      q_q   <= '0;
      rco_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
    end
  end

  assign oQ   = q_q;
  assign oRco = rco_q;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed scenarios plus random stimulus
// compared against an arithmetic reference model, and a two-stage cascade.
module tb_mode_counter;

  localparam int unsigned Width = 4;
  localparam int unsigned Step  = 3;
  localparam int          Modulus = 1 << Width;

  logic             clk = 1'b0;
  logic             clr, enb, cin;
  logic [1:0]       mode;
  logic [Width-1:0] d;
  logic [Width-1:0] q;
  logic             rco;

  logic             c_clr, c_enb;
  logic [1:0]       c_mode;
  logic [Width-1:0] lo_d, hi_d, lo_q, hi_q;
  logic             lo_rco, hi_rco;

  int n_vec = 0;
  int n_err = 0;
  int mq    = 0;
  int mrco  = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(Width), .STEP(Step)) u_dut (
    .iClk(clk), .iClr(clr), .iEnb(enb), .iCarryIn(cin), .iMode(mode), .iD(d),
    .oQ(q), .oRco(rco)
  );

  mode_counter #(.WIDTH(Width), .STEP(Step)) u_lo (
    .iClk(clk), .iClr(c_clr), .iEnb(c_enb), .iCarryIn(1'b1), .iMode(c_mode), .iD(lo_d),
    .oQ(lo_q), .oRco(lo_rco)
  );

  mode_counter #(.WIDTH(Width), .STEP(Step)) u_hi (
    .iClk(clk), .iClr(c_clr), .iEnb(c_enb), .iCarryIn(lo_rco), .iMode(c_mode), .iD(hi_d),
    .oQ(hi_q), .oRco(hi_rco)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: next state from the current model value and the applied inputs.
  task automatic step();
    int s;
    if (clr) begin
      mq = 0; mrco = 0;
    end else if (enb) begin
      mrco = 0;
    end else begin
      mrco = 0;
      case (mode)
        2'd0: if (cin) begin
          mrco = (mq == Modulus - 1) ? 1 : 0;
          mq   = (mq + 1) % Modulus;
        end
        2'd1: if (cin) begin
          mrco = (mq == 0) ? 1 : 0;
          mq   = (mq + Modulus - 1) % Modulus;
        end
        2'd2: if (cin) begin
          s    = mq + int'(Step);
          mrco = (s >= Modulus) ? 1 : 0;
          mq   = s % Modulus;
        end
        default: mq = int'(d);
      endcase
    end
    @(posedge clk);
    #1;
    check_val("q", int'(q), mq);
    check_val("rco", int'(rco), mrco);
  endtask

  int step_seq [7] = '{3, 6, 9, 12, 15, 2, 5};

  initial begin
    c_clr = 1'b1; c_enb = 1'b0; c_mode = 2'b00; lo_d = '0; hi_d = '0;
    clr = 1'b1; enb = 1'b0; cin = 1'b1; mode = 2'b00; d = '0;
    step();
    check_val("reset_q", int'(q), 0);
    check_val("reset_rco", int'(rco), 0);

    // Up count through the wrap.
    clr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i == 15) begin
        check_val("up_wrap_q", int'(q), 0);
        check_val("up_wrap_rco", int'(rco), 1);
      end
    end

    // Load A, then count down through the borrow.
    mode = 2'b11; d = 4'hA;
    step();
    check_val("load_a", int'(q), 10);
    mode = 2'b01;
    repeat (12) step();

    // Up-by-STEP from zero.
    mode = 2'b11; d = '0;
    step();
    mode = 2'b10;
    for (int i = 0; i < 7; i++) begin
      step();
      check_val("step_seq", int'(q), step_seq[i]);
      check_val("step_rco", int'(rco), (i == 5) ? 1 : 0);
    end

    // Hold via enable and via carry-in, then resume.
    mode = 2'b11; d = 4'h6;
    step();
    mode = 2'b00;
    step();
    enb = 1'b1;
    repeat (3) step();
    enb = 1'b0; cin = 1'b0;
    repeat (2) step();
    check_val("hold_q", int'(q), 7);
    cin = 1'b1;
    step();
    check_val("resume_q", int'(q), 8);

    // Reset mid-count, and reset beating load.
    mode = 2'b11; d = 4'hE;
    step();
    mode = 2'b00; clr = 1'b1;
    step();
    check_val("clr_mid_q", int'(q), 0);
    clr = 1'b0;
    step();
    mode = 2'b11; d = 4'h5; clr = 1'b1;
    step();
    check_val("clr_vs_load", int'(q), 0);
    clr = 1'b0;

    // Down from zero right after reversal flags the borrow.
    mode = 2'b01;
    step();
    check_val("rev_rco", int'(rco), 1);

    for (int i = 0; i < 600; i++) begin
      clr  = ($urandom_range(31) == 0);
      enb  = ($urandom_range(5) == 0);
      cin  = ($urandom_range(4) != 0);
      mode = 2'($urandom_range(3));
      d    = Width'($urandom);
      step();
    end

    // Cascade: low stage at F, high stage at 0, count up.
    c_clr = 1'b0; c_mode = 2'b11; lo_d = 4'hF; hi_d = 4'h0;
    @(posedge clk); #1;
    c_mode = 2'b00;
    @(posedge clk); #1;
    check_val("cas_lo_wrap", int'(lo_q), 0);
    check_val("cas_lo_rco", int'(lo_rco), 1);
    check_val("cas_hi_skew", int'(hi_q), 0);
    @(posedge clk); #1;
    check_val("cas_hi_adv", int'(hi_q), 1);
    check_val("cas_lo_next", int'(lo_q), 1);
    check_val("cas_lo_rco_off", int'(lo_rco), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
